sdram_req_sequencer: RTL and testbench
======================================

# sdram_req_sequencer

Host-side front end for the SDRAM controller. It buffers read and write requests from a valid/ready client in a small FIFO and issues them to the controller one at a time as single-cycle `rd_enable`/`wr_enable` pulses. It confirms that the controller accepted each command by watching `busy`, and re-issues any command the controller dropped while it was refreshing. It captures read data on `rd_ready` and returns it to the client as a one-cycle response.

## Interface
- `ADDR_WIDTH`, 24: host address width (bank + row + col).
- `DEPTH`, 4: request FIFO depth; must be a power of 2, ≥2.
- `ACK_TIMEOUT`, 16: cycles to wait for `busy` after a pulse before re-issuing; must be ≥4.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  client request valid.
- `req_ready`  out  1  FIFO not full; equals `~full`, combinational from the occupancy count.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  16  read data; held until the next response.
- `rsp_we`  out  1  type of the response (0 = read).
- `rd_addr`, `wr_addr`  out  ADDR_WIDTH  address to the controller; both driven from the FIFO head.
- `wr_data`  out  16  write data to the controller.
- `rd_enable`, `wr_enable`  out  1  command pulses to the controller.
- `busy`  in  1  controller busy.
- `rd_ready`  in  1  controller read-data strobe.
- `rd_data`  in  16  controller read data.
- `retry_cnt`  out  8  saturating count of re-issues.

## Operation
- **FIFO.**
  - A push happens when `req_valid & req_ready`.
  - A pop happens at command completion.
  - A push and a pop in the same cycle are allowed, so occupancy is unchanged.
  - When the FIFO is full, `req_ready` is 0 even if a pop occurs that same cycle.
  - Pointers wrap modulo `DEPTH`.
- **FSM states:** IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- **IDLE:**
  - Moves to ISSUE when the FIFO is non-empty and `busy` = 0.
  - Addresses and `wr_data` present the FIFO head continuously.
- **ISSUE:**
  - Drives exactly one cycle of `rd_enable` (read) or `wr_enable` (write). The other enable stays 0.
  - Clears the ack counter and the `rd_seen` flag.
  - Always moves to WAIT_ACK.
- **WAIT_ACK:**
  - `busy` = 1 moves to WAIT_DONE.
  - If the ack counter reaches `ACK_TIMEOUT`-1 with `busy` still 0, go to ISSUE (re-issue) and increment `retry_cnt`, saturating at 255.
- **WAIT_DONE:**
  - `rd_ready` = 1 latches `rd_data` into `rsp_data` and sets `rd_seen`.
  - On `busy` = 0, pop the FIFO and return to IDLE.
  - For a read, raise `rsp_valid` for one cycle with `rsp_we` = 0, in the cycle after `busy` falls.
- **Missing read strobe:** a read that completes with `rd_seen` = 0 still pops and pulses `rsp_valid`. `rsp_data` is then 16'h0000.
- **Response backpressure:** none; the client must accept every `rsp_valid`.
- **FIFO head stability:** the head entry is never modified while the FSM is outside IDLE.
- **Reset mid-operation:**
  - FIFO is flushed and the FSM returns to IDLE.
  - Any in-flight command is abandoned with no response.

## Timing
- **Reset values:** `rd_enable` = `wr_enable` = `rsp_valid` = `rsp_we` = 0. `rsp_data` = 0. `retry_cnt` = 0. Addresses and `wr_data` = 0. `req_ready` = 1.
- **Command latency:** a request pushed into an empty FIFO while `busy` = 0 produces its enable pulse 2 cycles after acceptance (push → IDLE sees non-empty → ISSUE).
- **Ack window:** `busy` is expected 2 cycles after the pulse. `ACK_TIMEOUT` covers the longest controller refresh sequence, during which the enable is ignored.
- **Pulse spacing:** enable pulses are separated by at least 3 cycles.
- **Registered outputs:** all outputs are registered except `req_ready`.

## Configuration
- `SDRAM_SEQ_WRITE_ACK_EN`:
  - **Defined:** write completion also pulses `rsp_valid` for one cycle, in the cycle after `busy` falls, with `rsp_we` = 1. `rsp_data` is unchanged.
  - **Undefined:** writes complete silently and `rsp_we` is tied to 0.

## Test plan
- **Single write then read.** Write addr 24'h012345 with data 16'hBEEF, then read the same address with a model returning 16'hBEEF.
  - `wr_enable` pulses once with the correct address/data.
  - Exactly one `rsp_valid` with `rsp_data` = 16'hBEEF.
  - `retry_cnt` = 0.
- **Back-to-back fill.** Push 5 requests with `DEPTH` = 4 and the controller held busy.
  - `req_ready` drops after the 4th push.
  - The 5th push is accepted only after the first pop.
  - Issue order is preserved.
- **Dropped command.** The model ignores the first `rd_enable` (refresh in progress).
  - Re-issue occurs exactly `ACK_TIMEOUT` cycles after WAIT_ACK entry.
  - `retry_cnt` = 1 and one response is produced.
- **Push and pop in the same cycle** with the FIFO at 2 entries: occupancy stays 2 and no entry is lost or duplicated.
- **Reset mid-read.** Assert `rst_n` = 0 during WAIT_DONE.
  - No `rsp_valid`, FIFO empty, all outputs at reset values the following cycle.
- **Write acknowledge.** With `SDRAM_SEQ_WRITE_ACK_EN` defined, a write yields `rsp_valid` = 1 with `rsp_we` = 1. Without it, no response is produced.

Source files
------------

// File: rtl/sdram_req_sequencer.sv
// Host-side request front end for the SDRAM controller: FIFO-buffered requests,
// single-cycle command pulses, busy-based acceptance with re-issue, read responses.
// Optional write acknowledge: define SDRAM_SEQ_WRITE_ACK_EN.
module sdram_req_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_data,
    output logic                  rsp_we,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  rd_enable,
    output logic                  wr_enable,
    input  logic                  busy,
    input  logic                  rd_ready,
    input  logic [15:0]           rd_data,
    output logic [7:0]            retry_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fifo_we_q    [DEPTH];
    logic                  fifo_we_d    [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d  [DEPTH];
    logic [15:0]           fifo_wdata_q [DEPTH];
    logic [15:0]           fifo_wdata_d [DEPTH];
    logic [ACK_W-1:0]      ack_cnt_q, ack_cnt_d;
    logic                  rd_seen_q, rd_seen_d;
    logic                  rd_enable_q, rd_enable_d;
    logic                  wr_enable_q, wr_enable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [15:0]           rsp_data_q, rsp_data_d;
    logic [7:0]            retry_cnt_q, retry_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wr_data_q, wr_data_d;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [15:0]           head_wdata;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign req_ready  = ~full;
    assign push       = req_valid & req_ready;
    assign head_we    = fifo_we_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];

`ifdef SDRAM_SEQ_WRITE_ACK_EN
    logic rsp_we_q, rsp_we_d;
    assign rsp_we = rsp_we_q;
`else
    assign rsp_we = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ack_cnt_d   = ack_cnt_q;
        rd_seen_d   = rd_seen_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        retry_cnt_d = retry_cnt_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        pop         = 1'b0;
`ifdef SDRAM_SEQ_WRITE_ACK_EN
        rsp_we_d    = rsp_we_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    addr_d    = head_addr;
                    wr_data_d = head_wdata;
                    if (!busy) state_d = ISSUE;
                end
            end
            ISSUE: begin
                ack_cnt_d = '0;
                rd_seen_d = 1'b0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                ack_cnt_d = ack_cnt_q + ACK_W'(1);
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    // Controller ignored the pulse (refresh in progress): issue again.
                    state_d = ISSUE;
                    if (retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (rd_ready && !head_we) begin
                    rsp_data_d = rd_data;
                    rd_seen_d  = 1'b1;
                end
                if (!busy) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                    if (!head_we) begin
                        rsp_valid_d = 1'b1;
                        if (!rd_seen_d) rsp_data_d = '0;
`ifdef SDRAM_SEQ_WRITE_ACK_EN
                        rsp_we_d    = 1'b0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_we_d    = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The enable register is high exactly for the cycle spent in ISSUE.
        rd_enable_d = (state_d == ISSUE) && !head_we;
        wr_enable_d = (state_d == ISSUE) && head_we;
    end

    always_comb begin
        fifo_we_d    = fifo_we_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_wdata_d = fifo_wdata_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (push) begin
            fifo_we_d[wr_ptr_q]    = req_we;
            fifo_addr_d[wr_ptr_q]  = req_addr;
            fifo_wdata_d[wr_ptr_q] = req_wdata;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        fifo_we_q    <= fifo_we_d;
        fifo_addr_q  <= fifo_addr_d;
        fifo_wdata_q <= fifo_wdata_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ack_cnt_q   <= '0;
            rd_seen_q   <= 1'b0;
            rd_enable_q <= 1'b0;
            wr_enable_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            retry_cnt_q <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ack_cnt_q   <= ack_cnt_d;
            rd_seen_q   <= rd_seen_d;
            rd_enable_q <= rd_enable_d;
            wr_enable_q <= wr_enable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            retry_cnt_q <= retry_cnt_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

`ifdef SDRAM_SEQ_WRITE_ACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) rsp_we_q <= 1'b0;
        else        rsp_we_q <= rsp_we_d;
    end
`endif

    assign rd_enable = rd_enable_q;
    assign wr_enable = wr_enable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign retry_cnt = retry_cnt_q;
    assign rd_addr   = addr_q;
    assign wr_addr   = addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_sdram_req_sequencer.sv
// Directed bench for sdram_req_sequencer with a behavioural SDRAM controller model.
`timescale 1ns/1ps
module tb_sdram_req_sequencer;
    localparam int ACK_T = 16;
`ifdef SDRAM_SEQ_WRITE_ACK_EN
    localparam int WACK = 1;
`else
    localparam int WACK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_we;
    logic [23:0] rd_addr;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_enable;
    logic        wr_enable;
    logic        busy;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [7:0]  retry_cnt;

    always #5 clk = ~clk;

    sdram_req_sequencer #(
        .ADDR_WIDTH (24),
        .DEPTH      (4),
        .ACK_TIMEOUT(ACK_T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_we    (rsp_we),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_enable (rd_enable),
        .wr_enable (wr_enable),
        .busy      (busy),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .retry_cnt (retry_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Controller model knobs
    int          drop_cnt    = 0;
    int          busy_len    = 3;
    bit          strobe_en   = 1'b1;
    bit          stall       = 1'b0;
    logic [15:0] model_rdata = '0;
    bit          m_is_rd;

    initial begin
        busy     = 1'b0;
        rd_ready = 1'b0;
        rd_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && (rd_enable || wr_enable)) begin
                m_is_rd = rd_enable;
                if (drop_cnt > 0) begin
                    drop_cnt--;
                end else begin
                    @(posedge clk); #1;
                    busy = 1'b1;
                    repeat (busy_len) begin @(posedge clk); #1; end
                    if (m_is_rd && strobe_en) begin
                        rd_ready = 1'b1;
                        rd_data  = model_rdata;
                        @(posedge clk); #1;
                        rd_ready = 1'b0;
                    end
                    while (stall) begin @(posedge clk); #1; end
                    busy = 1'b0;
                end
            end
        end
    end

    // Monitor: logs command pulses and responses, counts protocol violations
    int          p_cyc[$];
    bit          p_rd[$];
    logic [23:0] p_addr[$];
    logic [15:0] p_wdata[$];
    logic [15:0] r_data[$];
    bit          r_we[$];
    int          proto_err = 0;
    int          last_pcyc = -100;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rd_enable || wr_enable) begin
                p_cyc.push_back(cyc);
                p_rd.push_back(rd_enable);
                p_addr.push_back(rd_addr);
                p_wdata.push_back(wr_data);
                if (rd_enable && wr_enable) proto_err++;
                if (rd_addr !== wr_addr) proto_err++;
                if (cyc - last_pcyc < 3) proto_err++;
                last_pcyc = cyc;
            end
            if (rsp_valid) begin
                r_data.push_back(rsp_data);
                r_we.push_back(rsp_we);
            end
        end
    end

    task automatic clear_logs();
        p_cyc.delete(); p_rd.delete(); p_addr.delete(); p_wdata.delete();
        r_data.delete(); r_we.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [23:0] a, input logic [15:0] d, output int acc);
        int t;
        t = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, expected 1", t);
            req_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc;
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_rd_enable"}, rd_enable, 0);
        chk({p, "_wr_enable"}, wr_enable, 0);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_rsp_we"},    rsp_we,    0);
        chk({p, "_rsp_data"},  rsp_data,  0);
        chk({p, "_retry_cnt"}, retry_cnt, 0);
        chk({p, "_rd_addr"},   rd_addr,   0);
        chk({p, "_wr_addr"},   wr_addr,   0);
        chk({p, "_wr_data"},   wr_data,   0);
        chk({p, "_req_ready"}, req_ready, 1);
    endtask

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          drops;
        bit          strobe;
        int          exp_pulses;
        int          exp_rsp;
        logic [15:0] exp_data;
        logic        exp_we;
        int          exp_retry;
    } vec_t;

    vec_t vecs [6];
    int   acc, acc5, rel_cyc;
    bit   push5_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // we addr wdata rdata drops strobe | pulses rsp data rsp_we retry
        vecs[0] = '{1'b1, 24'h012345, 16'hBEEF, 16'h0000, 0, 1'b0, 1, WACK, 16'h0000, 1'b1, 0};
        vecs[1] = '{1'b0, 24'h012345, 16'h0000, 16'hBEEF, 0, 1'b1, 1, 1,    16'hBEEF, 1'b0, 0};
        vecs[2] = '{1'b0, 24'hFFFFFF, 16'h0000, 16'h0001, 1, 1'b1, 2, 1,    16'h0001, 1'b0, 1};
        vecs[3] = '{1'b1, 24'h000000, 16'hFFFF, 16'h0000, 2, 1'b0, 3, WACK, 16'h0001, 1'b1, 3};
        vecs[4] = '{1'b0, 24'hABCDEF, 16'h0000, 16'h1234, 0, 1'b0, 1, 1,    16'h0000, 1'b0, 3};
        vecs[5] = '{1'b0, 24'h800001, 16'h0000, 16'hA5A5, 0, 1'b1, 1, 1,    16'hA5A5, 1'b0, 3};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 6; i++) begin
            clear_logs();
            drop_cnt    = vecs[i].drops;
            strobe_en   = vecs[i].strobe;
            model_rdata = vecs[i].rdata;
            push(vecs[i].we, vecs[i].addr, vecs[i].wdata, acc);
            wait_cycles(30 + 20 * vecs[i].drops);
            chk($sformatf("v%0d_pulses", i), p_cyc.size(), vecs[i].exp_pulses);
            if (p_cyc.size() > 0) begin
                chk($sformatf("v%0d_latency", i), p_cyc[0] - acc, 2);
                chk($sformatf("v%0d_is_read", i), p_rd[0], !vecs[i].we);
                chk($sformatf("v%0d_addr", i), p_addr[0], vecs[i].addr);
                chk($sformatf("v%0d_wdata", i), p_wdata[0], vecs[i].wdata);
            end
            if (vecs[i].drops > 0 && p_cyc.size() > 1)
                chk($sformatf("v%0d_reissue_gap", i), p_cyc[1] - p_cyc[0], ACK_T + 1);
            chk($sformatf("v%0d_rsp_count", i), r_data.size(), vecs[i].exp_rsp);
            if (r_data.size() > 0) begin
                chk($sformatf("v%0d_rsp_data", i), r_data[0], vecs[i].exp_data);
                chk($sformatf("v%0d_rsp_we", i), r_we[0], vecs[i].exp_we);
            end
            chk($sformatf("v%0d_retry_cnt", i), retry_cnt, vecs[i].exp_retry);
        end

        // retry counter saturation
        clear_logs();
        drop_cnt = 260; strobe_en = 1'b1; model_rdata = 16'h0F0F;
        push(1'b0, 24'h00AAAA, 16'h0000, acc);
        wait_cycles(261 * (ACK_T + 1) + 40);
        chk("sat_retry_cnt", retry_cnt, 255);
        chk("sat_pulses", p_cyc.size(), 261);
        chk("sat_rsp_count", r_data.size(), 1);
        if (r_data.size() > 0) chk("sat_rsp_data", r_data[0], 16'h0F0F);

        // back-to-back fill with the controller held busy
        clear_logs();
        busy_len = 2; stall = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 24'h000100 + 24'(i), 16'h1000 + 16'(i), acc);
        chk("fill_ready_after4", req_ready, 0);
        push5_done = 1'b0;
        fork
            begin
                push(1'b1, 24'h000104, 16'h1004, acc5);
                push5_done = 1'b1;
            end
            begin
                wait_cycles(10);
                chk("fill_5th_held", push5_done, 0);
                chk("fill_ready_held", req_ready, 0);
                #2;
                rel_cyc = cyc;
                stall = 1'b0;
            end
        join
        @(posedge clk); #1;
        chk("fill_5th_accept_after_pop", acc5 - rel_cyc, 2);
        wait_cycles(80);
        chk("fill_pulses", p_cyc.size(), 5);
        for (int i = 0; i < 5; i++)
            if (p_addr.size() > i) chk($sformatf("fill_order%0d", i), p_addr[i], 24'h000100 + 24'(i));

        // push and pop in the same cycle with two entries queued
        clear_logs();
        stall = 1'b1;
        push(1'b1, 24'h000200, 16'h2000, acc);
        push(1'b1, 24'h000201, 16'h2001, acc);
        wait_cycles(8);
        #2;
        stall = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h000202; req_wdata = 16'h2002;
        chk("pp_ready", req_ready, 1);
        chk("pp_busy_dropping", busy, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        stall = 1'b1;
        push(1'b1, 24'h000203, 16'h2003, acc);
        chk("pp_ready_at3", req_ready, 1);
        push(1'b1, 24'h000204, 16'h2004, acc);
        chk("pp_ready_at4", req_ready, 0);
        stall = 1'b0;
        wait_cycles(80);
        chk("pp_pulses", p_cyc.size(), 5);
        for (int i = 0; i < 5; i++)
            if (p_addr.size() > i) chk($sformatf("pp_order%0d", i), p_addr[i], 24'h000200 + 24'(i));

        // reset while a read sits in WAIT_DONE with a second read queued
        clear_logs();
        stall = 1'b1; strobe_en = 1'b1; model_rdata = 16'h5A5A; drop_cnt = 0;
        push(1'b0, 24'h000300, 16'h0000, acc);
        push(1'b0, 24'h000301, 16'h0000, acc);
        wait_cycles(10);
        chk("rst_mid_no_rsp_yet", r_data.size(), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset("rst_mid");
        rst_n = 1'b1;
        stall = 1'b0;
        wait_cycles(40);
        chk("rst_mid_pulses", p_cyc.size(), 1);
        chk("rst_mid_rsp", r_data.size(), 0);
        chk("rst_mid_ready", req_ready, 1);

        chk("protocol_violations", proto_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
